// File: rtl/onchip_burst_ram_pkg.sv
// Shared types and default parameter values for the on-chip burst RAM.
package onchip_burst_ram_pkg;

  localparam int    DEF_DATA_WIDTH  = 32;
  localparam int    DEF_ADDR_WIDTH  = 16;
  localparam int    DEF_DEPTH       = 42500;
  localparam int    DEF_BURST_WIDTH = 4;
  localparam string DEF_INIT_FILE   = "onchip_burst_ram.hex";

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } state_t;

endpackage

// File: rtl/onchip_burst_ram_if.sv
// Avalon-MM burst slave bus plus the freeze/reset_req stall requests.
interface onchip_burst_ram_if
  import onchip_burst_ram_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int BURST_WIDTH = DEF_BURST_WIDTH
);

  logic [ADDR_WIDTH-1:0]   address;
  logic [BURST_WIDTH-1:0]  burstcount;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    freeze;
  logic                    reset_req;
  logic                    waitrequest;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;

  modport master (
    output address, burstcount, read, write, writedata, byteenable,
    output freeze, reset_req,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, burstcount, read, write, writedata, byteenable,
    input  freeze, reset_req,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/onchip_burst_ram_array.sv
// Inferred single-port RAM: byte-lane writes, registered 1-cycle read, clock enable.
module onchip_burst_ram_array
  import onchip_burst_ram_pkg::*;
#(
  parameter int    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int    DEPTH      = DEF_DEPTH,
  parameter string INIT_FILE  = DEF_INIT_FILE
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int LANES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/onchip_burst_ram.sv
// Avalon-MM burst-capable on-chip RAM with freeze/reset_req stalling and address wrap.
module onchip_burst_ram
  import onchip_burst_ram_pkg::*;
#(
  parameter int    DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int    ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int    DEPTH       = DEF_DEPTH,
  parameter int    BURST_WIDTH = DEF_BURST_WIDTH,
  parameter string INIT_FILE   = DEF_INIT_FILE
) (
  input logic               clk,
  input logic               reset_n,
  onchip_burst_ram_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [BURST_WIDTH-1:0] ONE       = BURST_WIDTH'(1);

  state_t                 state, state_n;
  logic [ADDR_WIDTH-1:0]  beat_addr, beat_addr_n, ram_addr;
  logic [BURST_WIDTH-1:0] beat_cnt, beat_cnt_n, cmd_cnt;
  logic                   stall, ram_en, ram_we, issue;
  logic                   rvalid_q, oor_q;
  logic [DATA_WIDTH-1:0]  ram_q, hold_q, beat_data;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < (ADDR_WIDTH+1)'(DEPTH);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  assign stall            = bus.freeze | bus.reset_req;
  assign cmd_cnt          = (bus.burstcount == '0) ? ONE : bus.burstcount;
  assign bus.waitrequest  = ~reset_n | stall | (state == RD_BURST);

  // The first write beat lands on the acceptance edge, so IDLE drives the RAM directly.
  always_comb begin
    state_n     = state;
    beat_addr_n = beat_addr;
    beat_cnt_n  = beat_cnt;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = beat_addr;
    issue       = 1'b0;
    if (reset_n && !stall) begin
      case (state)
        IDLE: begin
          if (bus.write) begin
            ram_addr    = bus.address;
            ram_we      = in_range(bus.address);
            ram_en      = ram_we;
            beat_addr_n = next_addr(bus.address);
            beat_cnt_n  = cmd_cnt - 1'b1;
            if (cmd_cnt != ONE) state_n = WR_BURST;
          end else if (bus.read) begin
            beat_addr_n = bus.address;
            beat_cnt_n  = cmd_cnt;
            state_n     = RD_BURST;
          end
        end
        RD_BURST: begin
          issue       = 1'b1;
          ram_en      = in_range(beat_addr);
          beat_addr_n = next_addr(beat_addr);
          beat_cnt_n  = beat_cnt - 1'b1;
          if (beat_cnt == ONE) state_n = IDLE;
        end
        WR_BURST: begin
          if (bus.write) begin
            ram_we      = in_range(beat_addr);
            ram_en      = ram_we;
            beat_addr_n = next_addr(beat_addr);
            beat_cnt_n  = beat_cnt - 1'b1;
            if (beat_cnt == ONE) state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Stall freezes every register, so an in-flight beat is simply re-presented on resume.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      beat_addr <= '0;
      beat_cnt  <= '0;
      rvalid_q  <= 1'b0;
      oor_q     <= 1'b0;
      hold_q    <= '0;
    end else if (!stall) begin
      state     <= state_n;
      beat_addr <= beat_addr_n;
      beat_cnt  <= beat_cnt_n;
      rvalid_q  <= issue;
      if (issue)    oor_q  <= ~in_range(beat_addr);
      if (rvalid_q) hold_q <= beat_data;
    end
  end

  assign beat_data         = oor_q ? '0 : ram_q;
  assign bus.readdatavalid = rvalid_q & ~stall;
  assign bus.readdata      = bus.readdatavalid ? beat_data : hold_q;

  onchip_burst_ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .INIT_FILE  (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (bus.byteenable),
    .addr  (ram_addr),
    .wdata (bus.writedata),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_onchip_burst_ram.sv
// Directed bench for onchip_burst_ram: reference memory model feeds a readdata scoreboard.
module tb_onchip_burst_ram;
  import onchip_burst_ram_pkg::*;

  localparam int unsigned DEPTH = DEF_DEPTH;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  onchip_burst_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .BURST_WIDTH(4)) bus ();

  onchip_burst_ram #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (16),
    .DEPTH       (DEF_DEPTH),
    .BURST_WIDTH (4),
    .INIT_FILE   ("")
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned n_valid = 0;
  int unsigned base;
  logic [31:0] exp_q[$];
  logic [31:0] last_data = '0;
  logic [31:0] model [int unsigned];
  logic [31:0] wd [8];
  logic [3:0]  wb [8];

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endfunction

  function automatic logic [31:0] mread(input int unsigned a);
    if (a >= DEPTH || !model.exists(a)) return '0;
    return model[a];
  endfunction

  function automatic int unsigned anext(input int unsigned a);
    return (a == DEPTH - 1) ? 0 : a + 1;
  endfunction

  // Scoreboard: every valid beat pops one expectation; idle cycles must hold the last beat.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.readdatavalid) begin
        n_valid++;
        if (exp_q.size() == 0) chk("unexpected_valid", 32'(bus.readdatavalid), 32'd0);
        else begin
          last_data = exp_q.pop_front();
          chk("readdata", bus.readdata, last_data);
        end
      end else begin
        chk("readdata_hold", bus.readdata, last_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic take(input string tag);
    bit taken = 1'b0;
    for (int k = 0; k < 50 && !taken; k++) begin
      @(negedge clk);
      taken = !bus.waitrequest;
      tick();
    end
    if (!taken) chk({tag, "_accept_timeout"}, 32'(bus.waitrequest), 32'd0);
  endtask

  task automatic wr_burst(input int unsigned a, input int unsigned n,
                          input int unsigned sb, input int unsigned sc);
    int unsigned ne = (n == 0) ? 1 : n;
    int unsigned ba = a;
    logic [31:0] w;
    bus.address    = a[15:0];
    bus.burstcount = n[3:0];
    bus.write      = 1'b1;
    for (int unsigned i = 0; i < ne; i++) begin
      if (sc != 0 && i == sb) begin
        bus.reset_req  = 1'b1;
        bus.writedata  = 32'hBAD0_BAD0;
        bus.byteenable = 4'hF;
        repeat (sc) begin
          @(negedge clk);
          chk("stall_waitrequest", 32'(bus.waitrequest), 32'd1);
          tick();
        end
        bus.reset_req = 1'b0;
      end
      bus.writedata  = wd[i];
      bus.byteenable = wb[i];
      take("write");
      if (ba < DEPTH) begin
        w = mread(ba);
        for (int unsigned l = 0; l < 4; l++)
          if (wb[i][l]) w[8*l +: 8] = wd[i][8*l +: 8];
        model[ba] = w;
      end
      ba = anext(ba);
    end
    bus.write = 1'b0;
  endtask

  task automatic rd_issue(input int unsigned a, input int unsigned n);
    int unsigned ne = (n == 0) ? 1 : n;
    int unsigned ba = a;
    bus.address    = a[15:0];
    bus.burstcount = n[3:0];
    bus.read       = 1'b1;
    take("read");
    for (int unsigned i = 0; i < ne; i++) begin
      exp_q.push_back(mread(ba));
      ba = anext(ba);
    end
    bus.read = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick();
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_beats(input int unsigned target);
    for (int k = 0; k < 50 && n_valid < target; k++) tick();
    if (n_valid < target) chk("beat_timeout", n_valid, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.address = '0; bus.burstcount = '0; bus.read = 1'b0; bus.write = 1'b0;
    bus.writedata = '0; bus.byteenable = '0; bus.freeze = 1'b0; bus.reset_req = 1'b0;

    #2 reset_n = 1'b0;
    #1;
    chk("reset_waitrequest", 32'(bus.waitrequest), 32'd1);
    chk("reset_valid", 32'(bus.readdatavalid), 32'd0);
    chk("reset_readdata", bus.readdata, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("idle_waitrequest", 32'(bus.waitrequest), 32'd0);
    tick();

    // Preload 10..17 with A0..A7, then timed 4-beat read from 10.
    for (int i = 0; i < 8; i++) begin wd[i] = 32'hA0 + 32'(i); wb[i] = 4'hF; end
    wr_burst(10, 8, 0, 0);
    rd_issue(10, 4);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("rd_waitrequest", 32'(bus.waitrequest), 32'(k <= 4));
      chk("rd_valid", 32'(bus.readdatavalid), 32'(k >= 2 && k <= 5));
    end
    tick();
    drain();

    // Masked write burst over an all-ones preset.
    for (int i = 0; i < 3; i++) begin wd[i] = 32'hFFFF_FFFF; wb[i] = 4'hF; end
    wr_burst(100, 3, 0, 0);
    wd[0] = 32'h1111_1111; wb[0] = 4'hF;
    wd[1] = 32'h2222_2222; wb[1] = 4'h3;
    wd[2] = 32'h3333_3333; wb[2] = 4'h0;
    wr_burst(100, 3, 0, 0);
    rd_issue(100, 3);
    drain();

    // Wrap at the top word and out-of-range access.
    wd[0] = 32'hC0DE_0001; wd[1] = 32'hC0DE_0002; wb[0] = 4'hF; wb[1] = 4'hF;
    wr_burst(DEPTH - 1, 2, 0, 0);
    rd_issue(DEPTH - 1, 2);
    drain();
    rd_issue(0, 1);
    drain();
    wd[0] = 32'hDEAD_DEAD;
    wr_burst(50000, 1, 0, 0);
    rd_issue(50000, 1);
    drain();

    // Freeze for 3 cycles after the second beat of a 4-beat read.
    base = n_valid;
    rd_issue(10, 4);
    wait_beats(base + 2);
    bus.freeze = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("freeze_valid", 32'(bus.readdatavalid), 32'd0);
      tick();
    end
    bus.freeze = 1'b0;
    drain();
    chk("freeze_beat_count", n_valid - base, 32'd4);

    // reset_req held for 3 cycles before the third beat of a write burst.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hD000_0000 + 32'(i); wb[i] = 4'hF; end
    wr_burst(200, 4, 2, 3);
    rd_issue(200, 4);
    drain();

    // Back-to-back reads, second with burstcount 0 (one beat).
    rd_issue(12, 2);
    rd_issue(10, 0);
    drain();

    // Asynchronous reset during an 8-beat read.
    base = n_valid;
    rd_issue(10, 8);
    wait_beats(base + 2);
    reset_n = 1'b0;
    exp_q.delete();
    last_data = '0;
    #1;
    chk("midrst_valid", 32'(bus.readdatavalid), 32'd0);
    chk("midrst_waitrequest", 32'(bus.waitrequest), 32'd1);
    chk("midrst_readdata", bus.readdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("postrst_waitrequest", 32'(bus.waitrequest), 32'd0);
    chk("postrst_valid", 32'(bus.readdatavalid), 32'd0);
    tick();
    rd_issue(10, 8);
    drain();

    // Simultaneous read and write in IDLE: write wins, no read data.
    wd[0] = 32'h5A5A_5A5A; wb[0] = 4'hF;
    bus.read = 1'b1;
    wr_burst(5, 1, 0, 0);
    bus.read = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rw_no_valid", 32'(bus.readdatavalid), 32'd0);
    end
    tick();
    rd_issue(5, 1);
    drain();

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/onchip_burst_ram.md
ONCHIP_BURST_RAM -- requirements
Module: onchip_burst_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: word width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: word-address width.
REQ-003 SHALL have parameter DEPTH, default 42500: number of words, 1 <= DEPTH <= 2^ADDR_WIDTH, not necessarily a power of two.
REQ-004 SHALL have parameter BURST_WIDTH, default 4: burstcount width.
REQ-005 SHALL have parameter INIT_FILE, default "onchip_burst_ram.hex": memory initialisation file.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have ports address (in, ADDR_WIDTH), burstcount (in, BURST_WIDTH), read (in, 1) and write (in, 1): the Avalon-MM command.
REQ-009 SHALL have ports writedata (in, DATA_WIDTH) and byteenable (in, DATA_WIDTH/8): write beat data and lane enables.
REQ-010 SHALL have ports freeze (in, 1) and reset_req (in, 1): stall requests; stall = freeze | reset_req.
REQ-011 SHALL have ports waitrequest (out, 1), readdata (out, DATA_WIDTH) and readdatavalid (out, 1).

Function
REQ-012 SHALL implement FSM states IDLE, RD_BURST and WR_BURST.
REQ-013 SHALL drive waitrequest = 1 while reset_n is low, while stall is high, or in RD_BURST; otherwise 0.
REQ-014 SHALL accept a command in IDLE when (read | write) & ~waitrequest, latching address into the beat address and burstcount into the beat counter; burstcount 0 SHALL be treated as 1.
REQ-015 SHALL give write priority when read and write are both high in IDLE, and ignore read.
REQ-016 SHALL, for a read accepted at edge T with count N, issue one RAM read per cycle at T+1..T+N, assert readdatavalid with data at T+2..T+N+1 with no gaps, and return to IDLE after the Nth issue.
REQ-017 SHALL allow a new command to be accepted in the cycle of the last readdatavalid of the previous burst.
REQ-018 SHALL write the first write beat at the acceptance edge; if N > 1, enter WR_BURST and write one beat per cycle with write & ~waitrequest, returning to IDLE after the Nth beat; read SHALL be ignored in WR_BURST.
REQ-019 SHALL update only the byte lanes whose byteenable bit is 1; byteenable 0 SHALL consume a beat without changing memory.
REQ-020 SHALL increment the beat address by 1 per beat and wrap from DEPTH-1 to 0.
REQ-021 SHALL drop writes to an address >= DEPTH and return all-zero readdata (valid still asserted) for reads of such an address.
REQ-022 SHALL freeze FSM, counters, RAM enable and read pipeline while stall is high, force readdatavalid low, and resume on deassertion without losing or duplicating any beat.
REQ-023 SHALL hold readdata at its last value when readdatavalid is 0.

Reset
REQ-024 SHALL, on reset_n low, set FSM = IDLE, beat counter = 0, readdatavalid = 0 and readdata = 0, and abort any burst in progress.
REQ-025 SHALL retain memory contents across reset_n; INIT_FILE SHALL load only at configuration.
REQ-026 SHALL synchronise reset_n deassertion externally; the block SHALL not re-synchronise it.

Structure
REQ-027 SHALL place the FSM state enum and default parameter constants in package onchip_burst_ram_pkg.
REQ-028 SHALL contain one sub-module, onchip_burst_ram_array: an inferred single-port RAM with byte enables, synchronous 1-cycle read, clock enable and INIT_FILE.

Verification
REQ-029 Read burst: preload words 10..13 = 0xA0..0xA3; read addr 10, burstcount 4 at T -> readdatavalid T+2..T+5 with 0xA0, 0xA1, 0xA2, 0xA3; waitrequest high T+1..T+4.
REQ-030 Masked write burst: write addr 100, burstcount 3, data 0x11111111 / 0x22222222 / 0x33333333, byteenable 0xF / 0x3 / 0x0, over preset 0xFFFFFFFF -> reads return 0x11111111, 0xFFFF2222, 0xFFFFFFFF.
REQ-031 Wrap: write burst of 2 at addr DEPTH-1 (42499) -> beats land at 42499 and 0; a write to addr 50000 -> no change, and a read of 50000 returns 0 with valid.
REQ-032 Stall: freeze high 3 cycles after the second beat of a 4-beat read -> exactly 4 valid beats in order, none during freeze; reset_req during a write burst -> beats stalled, no write while high.
REQ-033 Reset mid-burst: reset_n low during beat 2 of an 8-beat read -> readdatavalid 0 immediately, FSM IDLE; prior contents read back unchanged.
REQ-034 Simultaneous read+write in IDLE: addr 5, data 0x5A5A5A5A -> word 5 written, no readdatavalid.
